// File: rtl/dma_periph_arb_pkg.sv
// Shared types and helpers for the DMA peripheral-request arbiter.
// Carries the FSM state encoding, index-width helpers and the round-robin pick.
package dma_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, CLR} arb_state_t;

    localparam int MAX_CH = 32;

    function automatic int pw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit at or after ptr, wrapping at n; caller guarantees cand != 0.
    function automatic logic [4:0] rr_pick(input logic [MAX_CH-1:0] cand,
                                           input logic [4:0]        ptr,
                                           input int                n);
        logic [4:0] pick;
        logic       found;
        logic [5:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = {1'b0, ptr} + 6'(i);
            if (idx >= 6'(n)) idx = idx - 6'(n);
            if (i < n && !found && cand[idx[4:0]]) begin
                pick  = idx[4:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dma_periph_arb_if.sv
// Grant handshake between the request arbiter (master) and the AXI channel engine (slave).
// One grant outstanding at a time; burst_done closes it.
interface dma_periph_arb_if #(parameter int NUM_CH = 8);

    logic                                 grant_valid;
    logic [dma_arb_pkg::cw_of(NUM_CH)-1:0] grant_ch;
    logic                                 grant_ready;
    logic                                 burst_done;
    logic                                 timeout_err;

    modport master (output grant_valid, grant_ch, timeout_err,
                    input  grant_ready, burst_done);

    modport slave  (input  grant_valid, grant_ch, timeout_err,
                    output grant_ready, burst_done);

endinterface

// File: rtl/dma_periph_arb_sync.sv
// Two-flop vector synchroniser for asynchronous peripheral request levels.
// Latency 2 cycles; no backpressure.
module dma_req_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/dma_periph_arb.sv
// Peripheral request front end: sync req lines, round-robin grant one channel, pulse clr on completion.
// Req->grant_valid 3 cycles; grant held until grant_ready; DMA_ARB_PRIO_EN adds a high-priority class.
module dma_periph_arb
    import dma_arb_pkg::*;
#(
    parameter int NUM_PERIPH  = 32,
    parameter int NUM_CH      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PERIPH-1:0]                periph_tx_req,
    input  logic [NUM_PERIPH-1:0]                periph_rx_req,
    output logic [NUM_PERIPH-1:0]                periph_tx_clr,
    output logic [NUM_PERIPH-1:0]                periph_rx_clr,
    input  logic [NUM_CH-1:0]                    ch_en,
    input  logic [NUM_CH-1:0]                    ch_dir,
    input  logic [NUM_CH*pw_of(NUM_PERIPH)-1:0]  ch_periph,
`ifdef DMA_ARB_PRIO_EN
    input  logic [NUM_CH-1:0]                    ch_prio,
`endif
    dma_periph_arb_if.master                     eng
);

    localparam int PW = pw_of(NUM_PERIPH);
    localparam int CW = cw_of(NUM_CH);
    localparam int WW = $clog2(TIMEOUT_CYC);

    logic [NUM_PERIPH-1:0] stx, srx;
    logic [NUM_CH-1:0]     sreq, elig, cand, mask;
    arb_state_t            state;
    logic [CW-1:0]         gch, rr_ptr;
    logic                  gv, terr;
    logic [WW-1:0]         wdog;
    logic [PW-1:0]         cur_p;
    logic                  cur_dir;

    dma_req_sync #(.W(NUM_PERIPH)) u_sync_tx (.clk(clk), .reset(reset), .d(periph_tx_req), .q(stx));
    dma_req_sync #(.W(NUM_PERIPH)) u_sync_rx (.clk(clk), .reset(reset), .d(periph_rx_req), .q(srx));

    always_comb begin
        logic [PW-1:0] pidx;
        sreq = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pidx    = ch_periph[c*PW +: PW];
            sreq[c] = ch_dir[c] ? stx[pidx] : srx[pidx];
        end
        elig = ch_en & ~mask & sreq;
`ifdef DMA_ARB_PRIO_EN
        cand = (|(elig & ch_prio)) ? (elig & ch_prio) : elig;
`else
        cand = elig;
`endif
        cur_p   = ch_periph[gch*PW +: PW];
        cur_dir = ch_dir[gch];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            gv            <= 1'b0;
            gch           <= '0;
            rr_ptr        <= '0;
            mask          <= '0;
            wdog          <= '0;
            terr          <= 1'b0;
            periph_tx_clr <= '0;
            periph_rx_clr <= '0;
        end else begin
            periph_tx_clr <= '0;
            periph_rx_clr <= '0;
            terr          <= 1'b0;
            // A masked channel re-arms once its peripheral has visibly dropped the request.
            mask          <= mask & sreq;
            case (state)
                IDLE: begin
                    if (|cand) begin
                        gch   <= CW'(rr_pick(MAX_CH'(cand), 5'(rr_ptr), NUM_CH));
                        gv    <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!ch_en[gch]) begin
                        gv    <= 1'b0;
                        state <= IDLE;
                    end else if (eng.grant_ready) begin
                        gv     <= 1'b0;
                        rr_ptr <= (gch == CW'(NUM_CH - 1)) ? '0 : gch + 1'b1;
                        wdog   <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (eng.burst_done) begin
                        state <= CLR;
                    end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
                        terr  <= 1'b1;
                        state <= CLR;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                CLR: begin
                    if (cur_dir) periph_tx_clr[cur_p] <= 1'b1;
                    else         periph_rx_clr[cur_p] <= 1'b1;
                    mask[gch] <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign eng.grant_valid = gv;
    assign eng.grant_ch    = gch;
    assign eng.timeout_err = terr;

endmodule

// File: tb/tb_dma_periph_arb.sv
// Scoreboard bench for dma_periph_arb: expected grants/clears/timeouts queued by stimulus,
// popped and compared by a negedge monitor.
module tb_dma_periph_arb;

    logic        clk;
    logic        rst_n;
    logic [7:0]  tx_req, rx_req, tx_clr, rx_clr;
    logic [7:0]  ch_en, ch_dir;
    logic [23:0] ch_periph;
`ifdef DMA_ARB_PRIO_EN
    logic [7:0]  ch_prio;
`endif

    dma_periph_arb_if #(.NUM_CH(8)) eng_if ();

    dma_periph_arb #(.NUM_PERIPH(8), .NUM_CH(8), .TIMEOUT_CYC(16)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .periph_tx_req (tx_req),
        .periph_rx_req (rx_req),
        .periph_tx_clr (tx_clr),
        .periph_rx_clr (rx_clr),
        .ch_en         (ch_en),
        .ch_dir        (ch_dir),
        .ch_periph     (ch_periph),
`ifdef DMA_ARB_PRIO_EN
        .ch_prio       (ch_prio),
`endif
        .eng           (eng_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_g[$];
    int exp_c[$];
    int exp_to = 0;
    int acc_cnt = 0;
    int nset, act;

    function automatic void chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endfunction

    // Monitor: every accepted grant, clear pulse and timeout pulse must match the next expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (eng_if.grant_valid && eng_if.grant_ready) begin
                acc_cnt++;
                if (exp_g.size() == 0) chk("grant_unexpected", int'(eng_if.grant_ch), -1);
                else                   chk("grant_ch", int'(eng_if.grant_ch), exp_g.pop_front());
            end
            nset = $countones(tx_clr) + $countones(rx_clr);
            if (nset != 0) begin
                act = -1;
                if (nset == 1) begin
                    for (int i = 0; i < 8; i++) begin
                        if (tx_clr[i]) act = 8 + i;
                        if (rx_clr[i]) act = i;
                    end
                end
                if (exp_c.size() == 0) chk("clr_unexpected", act, -99);
                else                   chk("clr_target", act, exp_c.pop_front());
            end
            if (eng_if.timeout_err) begin
                chk("timeout_expected", int'(exp_to > 0), 1);
                if (exp_to > 0) exp_to--;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int ch, input logic dir, input int p);
        ch_dir[ch]         = dir;
        ch_periph[ch*3 +: 3] = 3'(p);
    endtask

    task automatic wait_gv(output int n);
        n = 0;
        while (!eng_if.grant_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic grant_accept();
        int n;
        wait_gv(n);
        chk("grant_seen", int'(eng_if.grant_valid), 1);
        eng_if.grant_ready = 1'b1;
        @(posedge clk);
        #1;
        eng_if.grant_ready = 1'b0;
    endtask

    task automatic done_pulse();
        eng_if.burst_done = 1'b1;
        @(posedge clk);
        #1;
        eng_if.burst_done = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gv"},   int'(eng_if.grant_valid), 0);
        chk({tag, "_gch"},  int'(eng_if.grant_ch), 0);
        chk({tag, "_txclr"}, int'(tx_clr), 0);
        chk({tag, "_rxclr"}, int'(rx_clr), 0);
        chk({tag, "_terr"}, int'(eng_if.timeout_err), 0);
    endtask

    int t2_ch[4]  = '{1, 3, 6, 1};
    int t2_dir[4] = '{1, 0, 1, 1};

    initial begin
        int n, base;
        logic stable, seen;
        rst_n = 1'b0;
        tx_req = '0; rx_req = '0; ch_en = '0; ch_dir = '0; ch_periph = '0;
`ifdef DMA_ARB_PRIO_EN
        ch_prio = '0;
`endif
        eng_if.grant_ready = 1'b0;
        eng_if.burst_done  = 1'b0;

        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(2);

        // 1: single rx channel, latency and clear target
        cfg(0, 1'b0, 5);
        ch_en[0] = 1'b1;
        exp_g.push_back(0);
        rx_req[5] = 1'b1;
        wait_gv(n);
        chk("t1_grant_latency", n, 3);
        chk("t1_grant_ch", int'(eng_if.grant_ch), 0);
        grant_accept();
        cyc(2);
        exp_c.push_back(5);
        done_pulse();
        cyc(3);
        rx_req[5] = 1'b0;
        ch_en = '0;
        cyc(4);

        // 2: round robin over ch1/ch3/ch6 with grant_ready tied high
        cfg(1, 1'b1, 1); cfg(3, 1'b0, 3); cfg(6, 1'b1, 6);
        for (int k = 0; k < 4; k++) exp_g.push_back(t2_ch[k]);
        ch_en = 8'b0100_1010;
        tx_req[1] = 1'b1; rx_req[3] = 1'b1; tx_req[6] = 1'b1;
        eng_if.grant_ready = 1'b1;
        base = acc_cnt;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (acc_cnt < base + k + 1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("t2_accept_seen", int'(acc_cnt >= base + k + 1), 1);
            @(posedge clk);
            #1;
            exp_c.push_back(t2_dir[k] * 8 + t2_ch[k]);
            done_pulse();
            if (k == 3) begin
                ch_en = '0;
                eng_if.grant_ready = 1'b0;
            end else begin
                if (t2_dir[k] != 0) tx_req[t2_ch[k]] = 1'b0; else rx_req[t2_ch[k]] = 1'b0;
                cyc(4);
                if (t2_dir[k] != 0) tx_req[t2_ch[k]] = 1'b1; else rx_req[t2_ch[k]] = 1'b1;
            end
        end
        tx_req = '0; rx_req = '0;
        cyc(6);

        // 3: grant held without ready; stray burst_done ignored; ch_en drop withdraws grant
        cfg(2, 1'b0, 2);
        ch_en[2] = 1'b1;
        rx_req[2] = 1'b1;
        exp_g.push_back(2);
        wait_gv(n);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) eng_if.burst_done = 1'b1;
            if (i == 5) eng_if.burst_done = 1'b0;
            @(posedge clk);
            #1;
            if (!eng_if.grant_valid || eng_if.grant_ch != 3'd2) stable = 1'b0;
        end
        chk("t3_hold_stable", int'(stable), 1);
        grant_accept();
        cyc(2);
        exp_c.push_back(2);
        done_pulse();
        cyc(3);
        rx_req[2] = 1'b0;
        ch_en = '0;
        cyc(4);
        cfg(4, 1'b1, 4);
        ch_en[4] = 1'b1;
        tx_req[4] = 1'b1;
        wait_gv(n);
        chk("t3_en_grant_seen", int'(eng_if.grant_valid), 1);
        ch_en[4] = 1'b0;
        @(posedge clk);
        #1;
        chk("t3_en_drop_gv", int'(eng_if.grant_valid), 0);
        tx_req[4] = 1'b0;
        cyc(4);

        // 4: watchdog abort 16 cycles after accept, then clear
        cfg(0, 1'b1, 0);
        ch_en[0] = 1'b1;
        tx_req[0] = 1'b1;
        exp_g.push_back(0);
        exp_c.push_back(8);
        exp_to = 1;
        grant_accept();
        n = 0;
        while (!eng_if.timeout_err && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_timeout_latency", n, 16);
        cyc(2);
        tx_req[0] = 1'b0;
        ch_en = '0;
        cyc(4);

        // 5: level request held after clear must not be re-granted until it drops
        cfg(7, 1'b0, 7);
        ch_en[7] = 1'b1;
        rx_req[7] = 1'b1;
        exp_g.push_back(7);
        exp_c.push_back(7);
        grant_accept();
        done_pulse();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (eng_if.grant_valid) seen = 1'b1;
        end
        chk("t5_no_regrant", int'(seen), 0);
        rx_req[7] = 1'b0;
        cyc(3);
        rx_req[7] = 1'b1;
        exp_g.push_back(7);
        exp_c.push_back(7);
        grant_accept();
        done_pulse();
        cyc(3);
        rx_req[7] = 1'b0;
        ch_en = '0;
        cyc(4);

        // 6a: reset in BUSY returns everything to zero with no clear pulse
        cfg(2, 1'b1, 2);
        ch_en[2] = 1'b1;
        tx_req[2] = 1'b1;
        exp_g.push_back(2);
        grant_accept();
        cyc(3);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        tx_req = '0;
        ch_en = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(6);

        // 6b: ch2 low class vs ch5 high class, rr_ptr back at 0
        cfg(2, 1'b1, 2); cfg(5, 1'b0, 5);
`ifdef DMA_ARB_PRIO_EN
        ch_prio = 8'b0010_0000;
        exp_g.push_back(5); exp_g.push_back(2);
        exp_c.push_back(5); exp_c.push_back(10);
`else
        exp_g.push_back(2); exp_g.push_back(5);
        exp_c.push_back(10); exp_c.push_back(5);
`endif
        ch_en = 8'b0010_0100;
        tx_req[2] = 1'b1;
        rx_req[5] = 1'b1;
        grant_accept();
        done_pulse();
`ifdef DMA_ARB_PRIO_EN
        ch_en[5] = 1'b0; rx_req[5] = 1'b0;
`else
        ch_en[2] = 1'b0; tx_req[2] = 1'b0;
`endif
        grant_accept();
        done_pulse();
        ch_en = '0;
        tx_req = '0;
        rx_req = '0;
        cyc(6);

        chk("grant_queue_drained", exp_g.size(), 0);
        chk("clr_queue_drained", exp_c.size(), 0);
        chk("timeout_drained", exp_to, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
